uart_alu_interface: RTL and testbench

// Sits directly downstream of the UART receiver and upstream of the UART transmitter.

---
 rtl/uart_alu_interface_if.sv | 26 ++
 rtl/uart_alu_interface.sv | 105 ++++++++++
 tb/tb_uart_alu_interface.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_interface_if.sv
// rtl/uart_alu_interface_if.sv - receiver/ALU/transmitter signal bundle for uart_alu_interface
// master: the framing block; slave: the UART receiver, ALU and transmitter around it.
interface uart_alu_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_data_a;
  logic [NB_DATA-1:0] o_alu_data_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;

  modport master (
    input  i_rx_done_tick, i_rx_data, i_tx_done_tick, i_alu_result,
    output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_start, o_tx_data
  );

  modport slave (
    output i_rx_done_tick, i_rx_data, i_tx_done_tick, i_alu_result,
    input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_start, o_tx_data
  );
endinterface

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - frames rx bytes into A/B/opcode, returns ALU result to tx
// Done ticks are edge-detected so a level held across many cycles counts once.
module uart_alu_interface #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_STATE = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  uart_alu_interface_if.master bus
);

  typedef enum logic [NB_STATE-1:0] {
    S_GET_A   = NB_STATE'(0),
    S_GET_B   = NB_STATE'(1),
    S_GET_OP  = NB_STATE'(2),
    S_CALC    = NB_STATE'(3),
    S_SEND    = NB_STATE'(4),
    S_WAIT_TX = NB_STATE'(5)
  } state_t;

  state_t             state_q, state_d;
  logic               rx_prev_q, tx_prev_q;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start;
  logic               rx_ev, tx_ev;

  // Prev flags reset high so a done level already present at release is not an event.
  assign rx_ev = bus.i_rx_done_tick & ~rx_prev_q;
  assign tx_ev = bus.i_tx_done_tick & ~tx_prev_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_GET_A;
      rx_prev_q <= 1'b1;
      tx_prev_q <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= bus.i_rx_done_tick;
      tx_prev_q <= bus.i_tx_done_tick;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    case (state_q)
      S_GET_A: begin
        if (rx_ev) begin
          alu_a_d = bus.i_rx_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (rx_ev) begin
          alu_b_d = bus.i_rx_data;
          state_d = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (rx_ev) begin
          alu_op_d = bus.i_rx_data[NB_OP-1:0];
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        tx_data_d = bus.i_alu_result;
        state_d   = S_SEND;
      end
      S_SEND: begin
        tx_start = 1'b1;
        state_d  = S_WAIT_TX;
      end
      // Bytes arriving here are dropped; only the transmitter's done edge releases us.
      S_WAIT_TX: begin
        if (tx_ev) begin
          state_d = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  assign bus.o_alu_data_a = alu_a_q;
  assign bus.o_alu_data_b = alu_b_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_start   = tx_start;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - bench for uart_alu_interface
// Frame-level model: bytes fill A, B, opcode unless a result is outstanding.
module tb_uart_alu_interface;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  uart_alu_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_STATE(3)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_ref(bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op);

  int start_cnt  = 0;
  int double_cnt = 0;
  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      if (prev_start) double_cnt++;
      start_cnt++;
    end
    prev_start = (bus.o_tx_start === 1'b1);
  end

  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  int         m_idx;
  bit         m_busy;
  int         m_starts;

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    m_idx = 0; m_busy = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_busy) begin
      case (m_idx)
        0: m_a = b;
        1: m_b = b;
        default: begin
          m_op = b[5:0];
          m_tx = alu_ref(m_a, m_b, m_op);
          m_busy = 1'b1;
          m_starts++;
        end
      endcase
      m_idx = (m_idx + 1) % 3;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.i_rx_data = b;
    bus.i_rx_done_tick = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.i_rx_done_tick = 1'b0;
    bus.i_rx_data = $urandom;
    @(posedge clk); #1;
    model_byte(b);
  endtask

  task automatic pulse_tx();
    @(posedge clk); #1 bus.i_tx_done_tick = 1'b1;
    @(posedge clk); #1 bus.i_tx_done_tick = 1'b0;
  endtask

  task automatic tx_done_after(input int n);
    repeat (n) @(posedge clk);
    pulse_tx();
    m_busy = 1'b0;
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.i_rx_data = 8'h77;
    bus.i_rx_done_tick = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_alu_data_a !== m_a || bus.o_alu_data_b !== m_b || bus.o_alu_op !== m_op) begin
      failures++;
      $display("FAIL reset_fields got a=%h b=%h op=%h exp a=%h b=%h op=%h",
               bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, m_a, m_b, m_op);
    end
    checks++;
    if (bus.o_tx_data !== 8'h00 || bus.o_tx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx got data=%h start=%b exp data=00 start=0",
               bus.o_tx_data, bus.o_tx_start);
    end
    bus.i_rx_done_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    send_byte(8'h05, 1);
    @(negedge clk);
    checks++;
    if (bus.o_alu_data_a !== 8'h05) begin
      failures++;
      $display("FAIL add_a got=%h exp=05", bus.o_alu_data_a);
    end
    send_byte(8'h03, 1);
    send_byte(8'h20, 1);
    @(negedge clk);
    checks++;
    if (bus.o_alu_data_b !== 8'h03 || bus.o_alu_op !== 6'h20) begin
      failures++;
      $display("FAIL add_b_op got b=%h op=%h exp b=03 op=20", bus.o_alu_data_b, bus.o_alu_op);
    end
    checks++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h08) begin
      failures++;
      $display("FAIL add_latency got start=%b data=%h exp start=1 data=08",
               bus.o_tx_start, bus.o_tx_data);
    end
    @(negedge clk);
    checks++;
    if (bus.o_tx_start !== 1'b0 || start_cnt != m_starts) begin
      failures++;
      $display("FAIL add_pulse got start=%b count=%0d exp start=0 count=%0d",
               bus.o_tx_start, start_cnt, m_starts);
    end
    tx_done_after(10);
  endtask

  task automatic test_held_tick();
    logic [7:0] bytes [3];
    bit ok;
    bytes[0] = $urandom; bytes[1] = $urandom; bytes[2] = 8'h26;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], 16);
      @(negedge clk);
      checks++;
      if (bus.o_alu_data_a !== m_a || bus.o_alu_data_b !== m_b || bus.o_alu_op !== m_op) begin
        failures++;
        $display("FAIL held_byte%0d got a=%h b=%h op=%h exp a=%h b=%h op=%h", i,
                 bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, m_a, m_b, m_op);
      end
    end
    wait_starts(m_starts, ok);
    checks++;
    if (!ok || start_cnt != m_starts || bus.o_tx_data !== m_tx) begin
      failures++;
      $display("FAIL held_result got data=%h starts=%0d exp data=%h starts=%0d",
               bus.o_tx_data, start_cnt, m_tx, m_starts);
    end
    tx_done_after(10);
  endtask

  task automatic test_drop_in_wait();
    bit ok;
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h20, 1);
    wait_starts(m_starts, ok);
    send_byte(8'hAA, 2);
    @(negedge clk);
    checks++;
    if (bus.o_alu_data_a !== m_a || bus.o_alu_data_b !== m_b || bus.o_alu_op !== m_op ||
        bus.o_tx_data !== m_tx) begin
      failures++;
      $display("FAIL drop_hold got a=%h b=%h op=%h data=%h exp a=%h b=%h op=%h data=%h",
               bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_op, bus.o_tx_data,
               m_a, m_b, m_op, m_tx);
    end
    tx_done_after(3);
    send_byte(8'h01, 1); send_byte(8'h01, 1); send_byte(8'h20, 1);
    wait_starts(m_starts, ok);
    checks++;
    if (!ok || bus.o_tx_data !== 8'h02 || bus.o_alu_data_a !== 8'h01 ||
        bus.o_alu_data_b !== 8'h01) begin
      failures++;
      $display("FAIL drop_next got data=%h a=%h b=%h exp data=02 a=01 b=01",
               bus.o_tx_data, bus.o_alu_data_a, bus.o_alu_data_b);
    end
    tx_done_after(10);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    bit ok;
    send_byte(8'h10, 1); send_byte(8'h20, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    base = start_cnt;
    @(negedge clk);
    checks++;
    if (bus.o_alu_data_a !== 8'h00 || bus.o_alu_data_b !== 8'h00 || bus.o_tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_clear got a=%h b=%h data=%h exp 00 00 00",
               bus.o_alu_data_a, bus.o_alu_data_b, bus.o_tx_data);
    end
    send_byte(8'h07, 1); send_byte(8'h02, 1); send_byte(8'h22, 1);
    wait_starts(m_starts, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || bus.o_tx_data !== 8'h05 || start_cnt - base != 1) begin
      failures++;
      $display("FAIL midreset_sub got data=%h pulses=%0d exp data=05 pulses=1",
               bus.o_tx_data, start_cnt - base);
    end
    tx_done_after(10);
  endtask

  task automatic test_opcode_mask();
    logic [7:0] a, b;
    bit ok;
    a = $urandom; b = $urandom;
    send_byte(a, 1); send_byte(b, 2); send_byte(8'hE2, 1);
    wait_starts(m_starts, ok);
    checks++;
    if (!ok || bus.o_alu_op !== 6'h22 || bus.o_tx_data !== 8'(a - b)) begin
      failures++;
      $display("FAIL opmask got op=%h data=%h exp op=22 data=%h",
               bus.o_alu_op, bus.o_tx_data, 8'(a - b));
    end
    tx_done_after(10);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [5];
    int base, base_dbl;
    bit ok;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;
    base = start_cnt;
    base_dbl = double_cnt;
    for (int f = 0; f < 5; f++) begin
      send_byte($urandom, $urandom_range(1, 4));
      if (f == 2) pulse_tx();
      send_byte($urandom, $urandom_range(1, 4));
      send_byte(ops[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6), $urandom_range(1, 4));
      wait_starts(m_starts, ok);
      checks++;
      if (!ok || bus.o_tx_data !== m_tx || bus.o_alu_op !== m_op) begin
        failures++;
        $display("FAIL b2b_frame%0d got data=%h op=%h exp data=%h op=%h",
                 f, bus.o_tx_data, bus.o_alu_op, m_tx, m_op);
      end
      tx_done_after(10);
    end
    checks++;
    if (start_cnt - base != 5 || double_cnt != base_dbl) begin
      failures++;
      $display("FAIL b2b_pulses got pulses=%0d doubles=%0d exp pulses=5 doubles=0",
               start_cnt - base, double_cnt - base_dbl);
    end
  endtask

  initial begin
    bus.i_rx_done_tick = 1'b0;
    bus.i_rx_data      = 8'h00;
    bus.i_tx_done_tick = 1'b0;
    m_starts = 0;
    model_reset();
    test_reset();
    test_add();
    test_held_tick();
    test_drop_in_wait();
    test_reset_mid_frame();
    test_opcode_mask();
    test_back_to_back();
    checks++;
    if (double_cnt != 0) begin
      failures++;
      $display("FAIL start_double got=%0d exp=0", double_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
